// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM state encoding, parity modes, defaults
package uart_pkg;

    // Transmitter FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // i_parity_mode encodings; 2'b11 is treated as no parity.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with one-entry holding register
//
// Sends start, NBITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Bit timing is OVERSAMPLE ticks of i_baud_rate per bit. A holding register
// lets the next frame start immediately after the last stop bit.
//
// Build option: UART_TX_PARITY_EN compiles in the PARITY state and parity
// logic; without it i_parity_mode is ignored and frames carry no parity bit.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   i_baud_rate    one-cycle tick at OVERSAMPLE x baud
//   i_tx_start     load i_data / i_parity_mode into the holding register
//   i_data         frame payload
//   i_parity_mode  00 none, 01 even, 10 odd, 11 none
//   o_tx_ready     holding register empty
//   o_tx_busy      a frame is on the line
//   o_tx_done      one-cycle pulse at the end of the last stop bit
//   o_tx           serial line, idles high
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_baud_rate,
    input  logic             i_tx_start,
    input  logic [NBITS-1:0] i_data,
    input  logic [1:0]       i_parity_mode,
    output logic             o_tx_ready,
    output logic             o_tx_busy,
    output logic             o_tx_done,
    output logic             o_tx
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NBITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NBITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_t        state, state_n;
    logic [TW-1:0]    tick_cnt, tick_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [NBITS-1:0] shift_reg, shift_n;
    logic [NBITS-1:0] hold_data, hold_data_n;
    logic             hold_valid, hold_valid_n;
    logic             done_n;
    logic             line_n;
    logic             bit_end;
    logic             load;

`ifdef UART_TX_PARITY_EN
    logic [1:0]       hold_mode, hold_mode_n;
    logic             par_bit, par_bit_n;
    logic             par_en, par_en_n;
`else
    logic             unused_parity_mode;
    assign unused_parity_mode = ^i_parity_mode;
`endif

    always_comb begin
        state_n      = state;
        tick_n       = tick_cnt;
        bit_n        = bit_cnt;
        shift_n      = shift_reg;
        hold_data_n  = hold_data;
        hold_valid_n = hold_valid;
        done_n       = 1'b0;
        load         = 1'b0;
        line_n       = 1'b1;
`ifdef UART_TX_PARITY_EN
        hold_mode_n  = hold_mode;
        par_bit_n    = par_bit;
        par_en_n     = par_en;
`endif

        bit_end = i_baud_rate && (tick_cnt == TICK_LAST);

        if (state != ST_IDLE && i_baud_rate) begin
            tick_n = bit_end ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (hold_valid) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = par_en ? ST_PARITY : ST_STOP;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        done_n = 1'b1;
                        bit_n  = '0;
                        // A pending frame starts on this very edge: no idle gap.
                        if (hold_valid) begin
                            load = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            state_n      = ST_START;
            shift_n      = hold_data;
            hold_valid_n = 1'b0;
            tick_n       = '0;
            bit_n        = '0;
`ifdef UART_TX_PARITY_EN
            par_en_n  = (hold_mode == PAR_EVEN) || (hold_mode == PAR_ODD);
            par_bit_n = (hold_mode == PAR_ODD) ? ~^hold_data : ^hold_data;
`endif
        end

        // Ready is low whenever hold_valid is set, so accept never collides
        // with a load of the holding register into the shifter.
        if (i_tx_start && o_tx_ready) begin
            hold_data_n  = i_data;
            hold_valid_n = 1'b1;
`ifdef UART_TX_PARITY_EN
            hold_mode_n  = i_parity_mode;
`endif
        end

        case (state_n)
            ST_START:  line_n = 1'b0;
            ST_DATA:   line_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_n = par_bit_n;
`endif
            default:   line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            o_tx       <= 1'b1;
            o_tx_ready <= 1'b1;
            o_tx_busy  <= 1'b0;
            o_tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            hold_mode  <= PAR_NONE;
            par_bit    <= 1'b0;
            par_en     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_n;
            bit_cnt    <= bit_n;
            shift_reg  <= shift_n;
            hold_data  <= hold_data_n;
            hold_valid <= hold_valid_n;
            o_tx       <= line_n;
            o_tx_ready <= ~hold_valid_n;
            o_tx_busy  <= (state_n != ST_IDLE);
            o_tx_done  <= done_n;
`ifdef UART_TX_PARITY_EN
            hold_mode  <= hold_mode_n;
            par_bit    <= par_bit_n;
            par_en     <= par_en_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame (8 data bits, x16, 1 stop)
module tb_uart_tx_frame;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_baud_rate = 1'b1;
    logic       i_tx_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [1:0] i_parity_mode = 2'b00;
    logic       o_tx_ready;
    logic       o_tx_busy;
    logic       o_tx_done;
    logic       o_tx;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    uart_tx_frame #(.NBITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_baud_rate  (i_baud_rate),
        .i_tx_start   (i_tx_start),
        .i_data       (i_data),
        .i_parity_mode(i_parity_mode),
        .o_tx_ready   (o_tx_ready),
        .o_tx_busy    (o_tx_busy),
        .o_tx_done    (o_tx_done),
        .o_tx         (o_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of a frame: slot 0 start, slots 1..8 data LSB first,
    // optional parity slot, then stop; unused slots read as 1.
    function automatic bit par_on(input logic [1:0] m);
`ifdef UART_TX_PARITY_EN
        return (m == 2'b01) || (m == 2'b10);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_slots(input logic [1:0] m);
        return 10 + (par_on(m) ? 1 : 0);
    endfunction

    function automatic logic [15:0] exp_bits(input logic [7:0] d, input logic [1:0] m);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = d[i];
        if (par_on(m)) b[9] = (m == 2'b01) ? ^d : ~^d;
        return b;
    endfunction

    // Called at a negedge; request is accepted on the following posedge.
    task automatic send(input logic [7:0] d, input logic [1:0] m);
        exp_t e;
        i_data = d;
        i_parity_mode = m;
        i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        e.data = d;
        e.mode = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_low(input int bound, output int waited, output bit found);
        waited = 0;
        found = (o_tx === 1'b0);
        while (!found && waited < bound) begin
            @(negedge clk);
            waited++;
            found = (o_tx === 1'b0);
        end
    endtask

    // Current negedge holds the first start-bit sample. Returns one level per
    // bit slot, whether every slot stayed constant, done pulses seen inside the
    // frame, and the sample one cycle after the frame.
    task automatic capture(input int slots, output logic [15:0] bits, output bit steady,
                           output int done_in, output logic done_after,
                           output logic tx_after, output int end_cyc);
        bits = '1;
        steady = 1'b1;
        done_in = 0;
        for (int s = 0; s < slots; s++) begin
            for (int k = 0; k < OS; k++) begin
                if (!(s == 0 && k == 0)) begin
                    @(negedge clk);
                    if (o_tx_done === 1'b1) done_in++;
                end
                if (k == 0) bits[s[3:0]] = o_tx;
                else if (o_tx !== bits[s[3:0]]) steady = 1'b0;
            end
        end
        @(negedge clk);
        done_after = o_tx_done;
        tx_after = o_tx;
        end_cyc = cyc;
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_tx_ready !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_hold: bad cycles %0d, required 0", bad);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_tx, o_tx_ready, o_tx_busy, o_tx_done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_values: tx/ready/busy/done %b, required 1100",
                     {o_tx, o_tx_ready, o_tx_busy, o_tx_done});
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_tx_ready !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: bad cycles %0d, required 0", bad);
        end
    endtask

    task automatic test_8n1;
        int waited, done_in, end_cyc;
        bit found, steady;
        logic [15:0] bits;
        logic done_after, tx_after;
        exp_t e;
        send(8'h97, 2'b00);
        n_cmp++;
        if (o_tx_ready !== 1'b0 || o_tx_busy !== 1'b0 || o_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_state: ready/busy/tx %b, required 001", {o_tx_ready, o_tx_busy, o_tx});
        end
        wait_low(20, waited, found);
        n_cmp++;
        if (!found || waited !== 1) begin
            n_fail++;
            $display("FAIL start_latency: found %0d after %0d cycles, required 1 after 1", found, waited);
        end
        n_cmp++;
        if (o_tx_ready !== 1'b1 || o_tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_flags: ready/busy %b, required 11", {o_tx_ready, o_tx_busy});
        end
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL 8n1_queue: empty, required one entry");
            return;
        end
        e = exp_q.pop_front();
        capture(exp_slots(e.mode), bits, steady, done_in, done_after, tx_after, end_cyc);
        n_cmp++;
        if (bits !== exp_bits(e.data, e.mode) || steady !== 1'b1) begin
            n_fail++;
            $display("FAIL 8n1_bits: got %b steady %0d, required %b steady 1",
                     bits, steady, exp_bits(e.data, e.mode));
        end
        n_cmp++;
        if (done_in !== 0 || done_after !== 1'b1 || tx_after !== 1'b1) begin
            n_fail++;
            $display("FAIL 8n1_done: in-frame %0d at-end %b line %b, required 0 1 1",
                     done_in, done_after, tx_after);
        end
        @(negedge clk);
        n_cmp++;
        if (o_tx_done !== 1'b0 || o_tx_busy !== 1'b0 || o_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL 8n1_after: done/busy/tx %b, required 001", {o_tx_done, o_tx_busy, o_tx});
        end
    endtask

    task automatic test_parity;
        int waited, done_in, end_cyc;
        bit found, steady;
        logic [15:0] bits;
        logic done_after, tx_after;
        logic [1:0] m;
        exp_t e;
        for (int mi = 1; mi < 4; mi++) begin
            m = mi[1:0];
            repeat (3) @(negedge clk);
            send(8'h97, m);
            wait_low(20, waited, found);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL parity_queue: empty, required one entry");
                return;
            end
            e = exp_q.pop_front();
            capture(exp_slots(e.mode), bits, steady, done_in, done_after, tx_after, end_cyc);
            n_cmp++;
            if (!found || bits !== exp_bits(e.data, e.mode) || steady !== 1'b1) begin
                n_fail++;
                $display("FAIL parity_bits mode %b: got %b steady %0d, required %b steady 1",
                         m, bits, steady, exp_bits(e.data, e.mode));
            end
            n_cmp++;
            if (done_in !== 0 || done_after !== 1'b1) begin
                n_fail++;
                $display("FAIL parity_length mode %b: in-frame done %0d end done %b, required 0 1",
                         m, done_in, done_after);
            end
        end
    endtask

    task automatic test_back_to_back;
        int waited, done_in1, done_in2, end1, end2, k;
        bit found, steady1, steady2;
        logic [15:0] bits1, bits2;
        logic da1, da2, ta1, ta2;
        exp_t e1, e2;
        repeat (3) @(negedge clk);
        send(8'h55, 2'b00);
        fork
            begin
                wait_low(20, waited, found);
                e1 = exp_q.pop_front();
                capture(exp_slots(e1.mode), bits1, steady1, done_in1, da1, ta1, end1);
                e2 = exp_q.pop_front();
                capture(exp_slots(e2.mode), bits2, steady2, done_in2, da2, ta2, end2);
            end
            begin
                k = 0;
                while (o_tx_ready !== 1'b1 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                send(8'hA3, 2'b00);
            end
        join
        n_cmp++;
        if (bits1 !== exp_bits(e1.data, e1.mode) || steady1 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got %b, required %b", bits1, exp_bits(e1.data, e1.mode));
        end
        n_cmp++;
        if (da1 !== 1'b1 || ta1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: done %b line %b after first stop, required 1 0", da1, ta1);
        end
        n_cmp++;
        if (bits2 !== exp_bits(e2.data, e2.mode) || steady2 !== 1'b1 || done_in2 !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: got %b done_in %0d, required %b done_in 0",
                     bits2, done_in2, exp_bits(e2.data, e2.mode));
        end
        n_cmp++;
        if (da2 !== 1'b1 || (end2 - end1) !== exp_slots(e2.mode) * OS) begin
            n_fail++;
            $display("FAIL b2b_spacing: done %b spacing %0d, required 1 and %0d",
                     da2, end2 - end1, exp_slots(e2.mode) * OS);
        end
    endtask

    task automatic test_overrun;
        int waited, done_in1, done_in2, end1, end2, k;
        bit found, steady1, steady2;
        logic [15:0] bits1, bits2;
        logic da1, da2, ta1, ta2;
        exp_t e1, e2;
        repeat (3) @(negedge clk);
        send(8'h3C, 2'b00);
        fork
            begin
                wait_low(20, waited, found);
                e1 = exp_q.pop_front();
                capture(exp_slots(e1.mode), bits1, steady1, done_in1, da1, ta1, end1);
                e2 = exp_q.pop_front();
                capture(exp_slots(e2.mode), bits2, steady2, done_in2, da2, ta2, end2);
            end
            begin
                k = 0;
                while (o_tx_ready !== 1'b1 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                send(8'h81, 2'b00);
                // Holding register is full now; these requests must be dropped.
                repeat (30) begin
                    i_data = 8'hFF;
                    i_tx_start = (o_tx_ready === 1'b0);
                    @(negedge clk);
                end
                i_tx_start = 1'b0;
            end
        join
        n_cmp++;
        if (bits1 !== exp_bits(e1.data, e1.mode) || bits2 !== exp_bits(e2.data, e2.mode)) begin
            n_fail++;
            $display("FAIL overrun_data: got %b %b, required %b %b", bits1, bits2,
                     exp_bits(e1.data, e1.mode), exp_bits(e2.data, e2.mode));
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (o_tx_busy !== 1'b0 || o_tx !== 1'b1 || da2 !== 1'b1 || ta2 !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_extra: busy %b line %b end done %b end line %b, required 0 1 1 1",
                     o_tx_busy, o_tx, da2, ta2);
        end
    endtask

    task automatic test_mid_reset;
        int waited, done_in, end_cyc, bad;
        bit found, steady;
        logic [15:0] bits;
        logic done_after, tx_after;
        exp_t e;
        repeat (3) @(negedge clk);
        send(8'h97, 2'b00);
        wait_low(20, waited, found);
        e = exp_q.pop_front();
        // Start slot plus three data slots plus half a slot: middle of data bit 3.
        repeat (OS + 3 * OS + OS / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_async: tx/busy/ready %b, required 101", {o_tx, o_tx_busy, o_tx_ready});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx_done !== 1'b0 || o_tx !== 1'b1 || o_tx_busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: bad cycles %0d, required 0", bad);
        end
        send(8'h5A, 2'b00);
        wait_low(20, waited, found);
        e = exp_q.pop_front();
        capture(exp_slots(e.mode), bits, steady, done_in, done_after, tx_after, end_cyc);
        n_cmp++;
        if (!found || bits !== exp_bits(e.data, e.mode) || steady !== 1'b1 || done_after !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_next: got %b done %b, required %b done 1",
                     bits, done_after, exp_bits(e.data, e.mode));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 `TX`. It supports configurable data width, oversampling ratio and stop-bit count, plus runtime even/odd/no parity. A one-entry holding register allows back-to-back frames with no idle gap. It sits between the host-side byte source and the serial line and is clocked by `clk`, with bit timing taken from the shared `BaudRateGenerator` tick.

## Interface
- `NBITS`, 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, 16: `i_baud_rate` ticks per serial bit; minimum 2.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `i_baud_rate` in 1: single-cycle tick at OVERSAMPLE × baud.
- `i_tx_start` in 1: request to load `i_data` and `i_parity_mode`.
- `i_data` in NBITS: frame payload, sent LSB first.
- `i_parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `o_tx_ready` out 1: holding register is empty, so a start request will be accepted.
- `o_tx_busy` out 1: a frame is on the line (state ≠ IDLE).
- `o_tx_done` out 1: one-cycle pulse when the last stop bit completes.
- `o_tx` out 1: serial line; idles high.

## Operation
- **Accept:** `i_tx_start && o_tx_ready` on an edge latches data and mode into the holding register and sets `hold_valid`.
  - Start requests while not ready are ignored; held data is never overwritten.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE → START:** taken when `hold_valid` is set.
  - Holding register moves into the shift register and `hold_valid` clears.
  - Parity bit is computed: even = ^data, odd = ~^data.
  - Tick counter and bit counter reset to 0.
- **Bit-end event:** `i_baud_rate` is high and tick_cnt == OVERSAMPLE−1. Tick counter increments only on `i_baud_rate` and wraps to 0 at each bit end.
- **Transitions on bit end:**
  - START → DATA.
  - DATA shifts right; after bit NBITS−1 it goes to PARITY if mode is even/odd, otherwise to STOP.
  - PARITY → STOP.
  - STOP ends after STOP_BITS bits.
- **Line levels by state:** START 0, DATA shift_reg[0], PARITY parity bit, STOP 1, IDLE 1.
- **End of STOP:**
  - `o_tx_done` pulses.
  - If `hold_valid` is set, the FSM goes directly to START, loading as in IDLE (zero-gap back-to-back).
  - Otherwise it returns to IDLE.
- **Simultaneous accept and transfer:** accept is blocked because `o_tx_ready` = 0 while `hold_valid` is set, so there is no conflict.
- **Reset, at any time including mid-frame:** state IDLE, `o_tx` = 1, `o_tx_ready` = 1, `o_tx_busy` = 0, `o_tx_done` = 0, counters 0, `hold_valid` = 0. Partial frames are dropped.

## Timing
- All outputs are registered.
- Latency from `i_tx_start` (cycle N) to the `o_tx` falling edge is 2 cycles (edge N+2), provided the FSM is in IDLE.
- `o_tx_ready` deasserts at N+1 and reasserts at N+2 when the frame starts.
- **Bit length:** exactly OVERSAMPLE ticks, except the start bit, which may be shortened by less than one tick period.
- **Frame length in ticks:** OVERSAMPLE × (1 + NBITS + P + STOP_BITS), where P = 1 if parity is enabled.
- `o_tx_done` is high for exactly one cycle, on the edge where the last STOP bit-end is registered.
- `i_baud_rate` high for more than one cycle counts one tick per cycle; this is not protected.

## Configuration
- **`UART_TX_PARITY_EN` defined:** parity logic and the PARITY state are compiled in, and `i_parity_mode` behaves as above.
- **`UART_TX_PARITY_EN` undefined:**
  - PARITY state and parity logic are removed, and DATA always goes to STOP.
  - `i_parity_mode` is ignored (port retained).
  - Frames are NBITS-N-STOP_BITS.

## Structure
- **Shared package `uart_pkg`:** FSM state encoding localparams (IDLE..STOP), parity-mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`), default `OVERSAMPLE`.
- **Counter widths:** `$clog2(OVERSAMPLE)` for the tick counter and `$clog2(NBITS)` for the bit counter.
- **Sub-modules:** none. Baud tick comes from the existing `BaudRateGenerator`, instantiated outside.

## Test plan
- **Reset idle:** hold `rst` = 0 for 5 cycles, then release → `o_tx` = 1, `o_tx_ready` = 1, `o_tx_busy` = 0, no `o_tx_done`, for 100 cycles.
- **8N1 frame:** NBITS = 8, OVERSAMPLE = 16, tick every cycle; send 151 (0x97) with mode 00.
  - `o_tx` = 0 from edge N+2 for 16 cycles.
  - Then bits 1,1,1,0,1,0,0,1 at 16 cycles each.
  - Then 1 for 16 cycles.
  - `o_tx_done` pulses once; 160 cycles in total.
- **Parity:** 0x97 (popcount 5).
  - With `UART_TX_PARITY_EN` defined: even mode gives parity bit 1, odd mode gives 0; frame is 176 cycles.
  - With `UART_TX_PARITY_EN` undefined: mode 01 still gives a 160-cycle frame.
- **Back-to-back:** send 0x55, then 0xA3 as soon as `o_tx_ready` rises.
  - Second start bit immediately follows the first stop bit with zero idle cycles.
  - Two `o_tx_done` pulses, 160 cycles apart.
- **Overrun:** assert `i_tx_start` with 0xFF while `o_tx_ready` = 0 → ignored; the held byte is sent unchanged.
- **Mid-frame reset:** assert `rst` = 0 during DATA bit 3 → `o_tx` = 1 and `o_tx_busy` = 0 asynchronously. After release, no `o_tx_done` occurs and the next frame is sent correctly.
